program_loader: RTL and testbench

Loads a program into instruction memory before the pipelined MIPS core runs, holding the core in `cpu_hold` until loading completes. It accepts a stream of symbolic instructions (kind plus register and immediate fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word. It writes the words to consecutive instruction-memory addresses starting at 0. It is the encoding counterpart of the core's control decoder and uses the same opcode/func assignments.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/program_loader_if.sv | 32 +++
 rtl/instr_encoder.sv | 35 +++
 rtl/program_loader.sv | 108 ++++++++++
 tb/tb_program_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/func constants, loader kind enumeration, error codes and loader states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  typedef enum logic [3:0] {
    KIND_AND  = 4'd0,
    KIND_OR   = 4'd1,
    KIND_ADD  = 4'd2,
    KIND_SUB  = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_ANDI = 4'd5,
    KIND_ADDI = 4'd6,
    KIND_LW   = 4'd7,
    KIND_SW   = 4'd8,
    KIND_J    = 4'd9,
    KIND_BEQ  = 4'd10,
    KIND_BNE  = 4'd11
  } kind_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, 5'd0, func};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - instruction stream, memory write port and status of the program loader.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic [1:0]        err;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, count
  );

  modport slave (
    input  start, in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational encoder from symbolic instruction fields to a 32-bit MIPS word.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_AND:  word = r_word(rs, rt, rd, FUNC_AND);
      KIND_OR:   word = r_word(rs, rt, rd, FUNC_OR);
      KIND_ADD:  word = r_word(rs, rt, rd, FUNC_ADD);
      KIND_SUB:  word = r_word(rs, rt, rd, FUNC_SUB);
      KIND_SLT:  word = r_word(rs, rt, rd, FUNC_SLT);
      KIND_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      KIND_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      KIND_LW:   word = i_word(OP_LW, rs, rt, imm);
      KIND_SW:   word = i_word(OP_SW, rs, rt, imm);
      KIND_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      KIND_BNE:  word = i_word(OP_BNE, rs, rt, imm);
      KIND_J:    word = {OP_J, target};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams encoded instructions into instruction memory while holding the core.
module program_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0]       enc_word;
  logic              enc_illegal;

  instr_encoder u_encoder (
    .kind    (bus.in_kind),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .imm     (bus.in_imm),
    .target  (bus.in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      err_q       <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          if (enc_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_ERR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = enc_word;
            ptr_d       = ptr_q + 1'b1;
            count_d     = count_q + 1'b1;
            // A last word landing in the final slot is a clean finish, not an overflow.
            if (bus.in_last) begin
              state_d = ST_DRAIN;
            end else if (ptr_q == PTR_MAX) begin
              err_d   = ERR_OVERFLOW;
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: state_d = (err_q == ERR_NONE) ? ST_DONE : ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = (state_q != ST_DONE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed table-driven bench for program_loader.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(8)) b8 ();
  program_loader_if #(.ADDR_W(2)) b2 ();

  program_loader #(.ADDR_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  program_loader #(.ADDR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];
  vec_t gap[3];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive8(input vec_t v, input logic last);
    b8.in_kind   = v.kind;
    b8.in_rs     = v.rs;
    b8.in_rt     = v.rt;
    b8.in_rd     = v.rd;
    b8.in_imm    = v.imm;
    b8.in_target = v.target;
    b8.in_last   = last;
    b8.in_valid  = 1'b1;
  endtask

  task automatic start8();
    @(negedge clk);
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
  endtask

  task automatic check_reset8(input string tag);
    chk({tag, " in_ready"},  b8.in_ready,  0);
    chk({tag, " mem_we"},    b8.mem_we,    0);
    chk({tag, " mem_addr"},  b8.mem_addr,  0);
    chk({tag, " mem_wdata"}, b8.mem_wdata, 0);
    chk({tag, " cpu_hold"},  b8.cpu_hold,  1);
    chk({tag, " done"},      b8.done,      0);
    chk({tag, " err"},       b8.err,       0);
    chk({tag, " count"},     b8.count,     0);
  endtask

  initial begin
    tbl[0]  = '{4'd2,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820};
    tbl[1]  = '{4'd6,  5'd0,  5'd2,  5'd7,  16'h0005, 26'h0,       32'h20020005};
    tbl[2]  = '{4'd7,  5'd1,  5'd4,  5'd0,  16'h0008, 26'h0,       32'h8C240008};
    tbl[3]  = '{4'd0,  5'd3,  5'd4,  5'd5,  16'h0000, 26'h0,       32'h00642824};
    tbl[4]  = '{4'd1,  5'd1,  5'd1,  5'd1,  16'h0000, 26'h0,       32'h00210825};
    tbl[5]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FFF822};
    tbl[6]  = '{4'd4,  5'd2,  5'd3,  5'd4,  16'h0000, 26'h0,       32'h0043202A};
    tbl[7]  = '{4'd5,  5'd7,  5'd8,  5'd0,  16'h00FF, 26'h0,       32'h30E800FF};
    tbl[8]  = '{4'd11, 5'd2,  5'd3,  5'd0,  16'h8000, 26'h0,       32'h14438000};
    tbl[9]  = '{4'd9,  5'd3,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
    tbl[10] = '{4'd10, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF};
    tbl[11] = '{4'd8,  5'd0,  5'd5,  5'd0,  16'h0004, 26'h0,       32'hAC050004};
    gap[0]  = '{4'd9,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h100,     32'h08000100};
    gap[1]  = '{4'd10, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF};
    gap[2]  = '{4'd8,  5'd0,  5'd5,  5'd0,  16'h0004, 26'h0,       32'hAC050004};

    b8.start = 0; b8.in_valid = 0; b8.in_kind = 0; b8.in_rs = 0; b8.in_rt = 0;
    b8.in_rd = 0; b8.in_imm = 0; b8.in_target = 0; b8.in_last = 0;
    b2.start = 0; b2.in_valid = 0; b2.in_kind = 0; b2.in_rs = 0; b2.in_rt = 0;
    b2.in_rd = 0; b2.in_imm = 0; b2.in_target = 0; b2.in_last = 0;

    #12;
    check_reset8("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full table streamed back to back, last flag on the final entry.
    start8();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive8(tbl[i], i == 11);
      @(posedge clk);
      #1;
      chk($sformatf("tbl mem_we[%0d]", i),    b8.mem_we,    1);
      chk($sformatf("tbl mem_addr[%0d]", i),  b8.mem_addr,  i);
      chk($sformatf("tbl mem_wdata[%0d]", i), b8.mem_wdata, tbl[i].exp);
      chk($sformatf("tbl count[%0d]", i),     b8.count,     i + 1);
    end
    chk("tbl drain in_ready", b8.in_ready, 0);
    chk("tbl drain done",     b8.done,     0);
    chk("tbl drain cpu_hold", b8.cpu_hold, 1);
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("tbl done",      b8.done,     1);
    chk("tbl cpu_hold",  b8.cpu_hold, 0);
    chk("tbl mem_we",    b8.mem_we,   0);
    chk("tbl count end", b8.count,    12);
    chk("tbl err",       b8.err,      0);

    // Gapped in_valid: no write strobes in the idle cycles.
    start8();
    chk("gap start count", b8.count, 0);
    chk("gap start done",  b8.done,  0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive8(gap[i], i == 2);
      @(posedge clk);
      #1;
      chk($sformatf("gap mem_we[%0d]", i),    b8.mem_we,    1);
      chk($sformatf("gap mem_addr[%0d]", i),  b8.mem_addr,  i);
      chk($sformatf("gap mem_wdata[%0d]", i), b8.mem_wdata, gap[i].exp);
      @(negedge clk);
      b8.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("gap idle mem_we[%0d]", i), b8.mem_we, 0);
    end
    chk("gap done",  b8.done,  1);
    chk("gap count", b8.count, 3);

    // Illegal kind as the second word.
    start8();
    @(negedge clk);
    drive8(tbl[0], 1'b0);
    @(posedge clk);
    #1;
    chk("ill w0 mem_we",   b8.mem_we,   1);
    chk("ill w0 mem_addr", b8.mem_addr, 0);
    @(negedge clk);
    b8.in_kind = 4'd13;
    @(posedge clk);
    #1;
    chk("ill mem_we",   b8.mem_we,   0);
    chk("ill err",      b8.err,      1);
    chk("ill in_ready", b8.in_ready, 0);
    chk("ill cpu_hold", b8.cpu_hold, 1);
    chk("ill count",    b8.count,    1);
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ill sticky err", b8.err,    1);
    chk("ill later we",   b8.mem_we, 0);
    start8();
    chk("ill start err",      b8.err,      0);
    chk("ill start in_ready", b8.in_ready, 1);
    chk("ill start count",    b8.count,    0);

    // start pulsed while loading is ignored.
    @(negedge clk);
    drive8(tbl[3], 1'b0);
    @(posedge clk);
    #1;
    chk("sil w0 count", b8.count, 1);
    @(negedge clk);
    b8.in_valid = 1'b0;
    start8();
    chk("sil count",    b8.count,    1);
    chk("sil in_ready", b8.in_ready, 1);
    @(negedge clk);
    drive8(tbl[4], 1'b0);
    @(posedge clk);
    #1;
    chk("sil w1 mem_addr",  b8.mem_addr,  1);
    chk("sil w1 mem_wdata", b8.mem_wdata, tbl[4].exp);
    chk("sil w1 count",     b8.count,     2);

    // Asynchronous reset in the middle of a write cycle.
    @(negedge clk);
    drive8(tbl[5], 1'b0);
    @(posedge clk);
    #1;
    chk("rst pre mem_we", b8.mem_we, 1);
    #2;
    rst = 1'b1;
    b8.in_valid = 1'b0;
    #1;
    check_reset8("midrst");
    @(negedge clk);
    rst = 1'b0;
    start8();
    @(negedge clk);
    drive8(tbl[6], 1'b1);
    @(posedge clk);
    #1;
    chk("post rst mem_addr",  b8.mem_addr,  0);
    chk("post rst mem_wdata", b8.mem_wdata, tbl[6].exp);
    chk("post rst count",     b8.count,     1);
    @(negedge clk);
    b8.in_valid = 1'b0;

    // Overflow on a four-word memory.
    @(negedge clk);
    b2.start = 1'b1;
    @(posedge clk);
    #1;
    b2.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b2.in_kind = tbl[i].kind; b2.in_rs = tbl[i].rs; b2.in_rt = tbl[i].rt;
      b2.in_rd = tbl[i].rd; b2.in_imm = tbl[i].imm; b2.in_target = tbl[i].target;
      b2.in_last = 1'b0; b2.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("ovf mem_we[%0d]", i),    b2.mem_we,    1);
      chk($sformatf("ovf mem_addr[%0d]", i),  b2.mem_addr,  i);
      chk($sformatf("ovf mem_wdata[%0d]", i), b2.mem_wdata, tbl[i].exp);
    end
    chk("ovf err",      b2.err,      2);
    chk("ovf in_ready", b2.in_ready, 0);
    chk("ovf count",    b2.count,    4);
    @(negedge clk);
    b2.in_kind = tbl[4].kind; b2.in_rs = tbl[4].rs; b2.in_rt = tbl[4].rt; b2.in_rd = tbl[4].rd;
    @(posedge clk);
    #1;
    chk("ovf fifth mem_we", b2.mem_we, 0);
    chk("ovf fifth count",  b2.count,  4);
    @(posedge clk);
    #1;
    chk("ovf end mem_we",   b2.mem_we,   0);
    chk("ovf end cpu_hold", b2.cpu_hold, 1);
    chk("ovf end done",     b2.done,     0);
    chk("ovf end err",      b2.err,      2);
    chk("ovf end in_ready", b2.in_ready, 0);
    b2.in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
